// File: rtl/mem_write_monitor.sv
// Run controller and store checker for the single-cycle MIPS computer: holds the CPU in reset,
// runs it, logs every data-memory store and reports pass, wrong-result or timeout.
module mem_write_monitor #(
  parameter int          N           = 32,
  parameter int unsigned RESULT_ADDR = 84,
  parameter logic [31:0] EXPECTED    = 32'h96,
  parameter int          TIMEOUT     = 1024,
  parameter int          CNT_W       = 16,
  parameter int          LOG_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             memwrite,
  input  logic [N-1:0]     dataadr,
  input  logic [N-1:0]     writedata,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail_mismatch,
  output logic             fail_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] write_count,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [N-1:0]     log_addr,
  output logic [N-1:0]     log_data,
  output logic             log_overflow
);

  localparam int AW = $clog2(LOG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_hold_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_write_count;
  logic             r_pass;
  logic             r_fail_mismatch;
  logic             r_fail_timeout;
  logic             r_log_overflow;

  logic [N-1:0]     r_mem_addr [LOG_DEPTH];
  logic [N-1:0]     r_mem_data [LOG_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;

  logic w_store;
  logic w_result_hit;
  logic w_result_ok;
  logic w_timeout;
  logic w_restart;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  // The bus is only meaningful while the CPU is out of reset.
  assign w_store      = (r_state == S_RUN) && memwrite;
  assign w_result_hit = w_store && (dataadr == N'(RESULT_ADDR));
  assign w_result_ok  = w_result_hit && (writedata == N'(EXPECTED));
  assign w_timeout    = (r_cycle_count == CNT_W'(TIMEOUT - 1));
  assign w_restart    = start && ((r_state == S_IDLE) || (r_state == S_PASS) || (r_state == S_FAIL));
  assign w_full       = (r_occ == (AW+1)'(LOG_DEPTH));
  assign w_pop        = (r_occ != '0) && log_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign w_push_ok    = w_store && (!w_full || w_pop);
  assign w_drop       = w_store && w_full && !w_pop;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold_cnt) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_result_hit)   w_state_next = w_result_ok ? S_PASS : S_FAIL;
        else if (w_timeout) w_state_next = S_FAIL;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= 1'b0;
      r_cycle_count   <= '0;
      r_write_count   <= '0;
      r_pass          <= 1'b0;
      r_fail_mismatch <= 1'b0;
      r_fail_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_restart) begin
        r_hold_cnt      <= 1'b0;
        r_cycle_count   <= '0;
        r_write_count   <= '0;
        r_pass          <= 1'b0;
        r_fail_mismatch <= 1'b0;
        r_fail_timeout  <= 1'b0;
      end else if (r_state == S_HOLD) begin
        r_hold_cnt <= ~r_hold_cnt;
      end else if (r_state == S_RUN) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
        if (w_store && (r_write_count != '1)) r_write_count <= r_write_count + CNT_W'(1);
        // A result store in the timeout cycle takes priority over the timeout.
        if (w_result_hit) begin
          r_pass          <= w_result_ok;
          r_fail_mismatch <= !w_result_ok;
        end else if (w_timeout) begin
          r_fail_timeout  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_log_overflow <= 1'b0;
    end else if (w_restart) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_log_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop) r_log_overflow <= 1'b1;
    end
  end

  // Storage has no reset; emptiness is tracked solely by r_occ.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_addr[r_wr_ptr] <= dataadr;
      r_mem_data[r_wr_ptr] <= writedata;
    end
  end

  assign cpu_reset     = (r_state != S_RUN);
  assign running       = (r_state == S_RUN);
  assign done          = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass          = r_pass;
  assign fail_mismatch = r_fail_mismatch;
  assign fail_timeout  = r_fail_timeout;
  assign cycle_count   = r_cycle_count;
  assign write_count   = r_write_count;
  assign log_valid     = (r_occ != '0);
  assign log_addr      = log_valid ? r_mem_addr[r_rd_ptr] : '0;
  assign log_data      = log_valid ? r_mem_data[r_rd_ptr] : '0;
  assign log_overflow  = r_log_overflow;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Randomized and directed bench for mem_write_monitor, compared every cycle against a
// queue-based reference model of the run/check rules.
module tb_mem_write_monitor;

  localparam int TO    = 16;
  localparam int DEPTH = 8;
  localparam int RES   = 84;
  localparam int EXPV  = 32'h96;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        log_ready = 1'b0;
  logic        cpu_reset, running, done, pass, fail_mismatch, fail_timeout;
  logic [15:0] cycle_count, write_count;
  logic        log_valid, log_overflow;
  logic [31:0] log_addr, log_data;

  mem_write_monitor #(.N(32), .RESULT_ADDR(RES), .EXPECTED(32'h96), .TIMEOUT(TO),
                      .CNT_W(16), .LOG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cpu_reset(cpu_reset),
    .running(running), .done(done), .pass(pass), .fail_mismatch(fail_mismatch),
    .fail_timeout(fail_timeout), .cycle_count(cycle_count), .write_count(write_count),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run phase as flags/counters, log as a queue of {addr, data}.
  bit          m_running, m_done, m_pass, m_fm, m_ft, m_ovf;
  int          m_hold_left, m_cyc, m_wc;
  logic [63:0] m_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_done = 0; m_pass = 0; m_fm = 0; m_ft = 0; m_ovf = 0;
    m_hold_left = 0; m_cyc = 0; m_wc = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit st, input bit mw, input logic [31:0] adr,
                            input logic [31:0] dat, input bit rdy);
    bit pop;
    pop = (m_q.size() > 0) && rdy;
    if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_running = 1;
    end else if (!m_running) begin
      if (st) begin
        model_reset();
        m_hold_left = 2;
      end else if (pop) begin
        void'(m_q.pop_front());
      end
    end else begin
      if (mw) begin
        if (m_wc < 65535) m_wc++;
        $display("store adr=0x%0h data=0x%0h run_cycle=%0d", adr, dat, m_cyc);
      end
      if (pop) void'(m_q.pop_front());
      if (mw) begin
        if (m_q.size() < DEPTH) m_q.push_back({adr, dat});
        else m_ovf = 1;
      end
      if (mw && adr == RES) begin
        m_running = 0; m_done = 1;
        if (dat == EXPV) m_pass = 1; else m_fm = 1;
      end else if (m_cyc == TO - 1) begin
        m_running = 0; m_done = 1; m_ft = 1;
      end
      m_cyc++;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    check_eq("cpu_reset", cpu_reset, !m_running);
    check_eq("running", running, m_running);
    check_eq("done", done, m_done);
    check_eq("pass", pass, m_pass);
    check_eq("fail_mismatch", fail_mismatch, m_fm);
    check_eq("fail_timeout", fail_timeout, m_ft);
    check_eq("cycle_count", cycle_count, 64'(m_cyc));
    check_eq("write_count", write_count, 64'(m_wc));
    check_eq("log_valid", log_valid, m_q.size() > 0);
    check_eq("log_addr", log_addr, head[63:32]);
    check_eq("log_data", log_data, head[31:0]);
    check_eq("log_overflow", log_overflow, m_ovf);
  endtask

  // One clock: drive inputs, compare current outputs, advance DUT and model together.
  task automatic cycle(input bit st, input bit mw, input logic [31:0] adr,
                       input logic [31:0] dat, input bit rdy);
    start = st; memwrite = mw; dataadr = adr; writedata = dat; log_ready = rdy;
    check_outputs();
    @(posedge clk);
    model_edge(st, mw, adr, dat, rdy);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    reset_n = 0; start = 0; memwrite = 0; log_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset_n = 1;
  endtask

  task automatic begin_run();
    cycle(1, 0, 32'd0, 32'd0, 0);
    idle(2, 0);
  endtask

  initial begin
    do_reset();

    // Pass run, then drain the log.
    begin_run();
    cycle(0, 1, 32'd80, 32'h7, 0);
    idle(1, 0);
    cycle(0, 1, 32'd84, 32'h96, 0);
    idle(2, 0);
    idle(3, 1);

    // Wrong result value.
    begin_run();
    idle(3, 0);
    cycle(0, 1, 32'd84, 32'h95, 0);
    idle(2, 0);

    // Timeout with no stores, bus activity ignored afterwards.
    begin_run();
    idle(TO, 0);
    cycle(0, 1, 32'd84, 32'h96, 0);
    idle(2, 1);

    // Result store in the last allowed cycle wins over the timeout.
    begin_run();
    idle(TO - 1, 0);
    cycle(0, 1, 32'd84, 32'h96, 0);
    idle(2, 0);

    // Overflow, then a push and pop together while full.
    begin_run();
    for (int i = 0; i < 10; i++) cycle(0, 1, 32'd0, 32'(i + 1), 0);
    cycle(0, 1, 32'd0, 32'hAB, 1);
    idle(TO, 0);
    idle(DEPTH + 2, 1);

    // Start during RUN is ignored.
    begin_run();
    cycle(1, 1, 32'd4, 32'h11, 0);
    cycle(1, 0, 32'd0, 32'd0, 0);
    cycle(0, 1, 32'd84, 32'h96, 1);
    idle(2, 0);

    // Randomized runs, including restarts from PASS/FAIL and starts mid-run.
    for (int r = 0; r < 40; r++) begin
      begin_run();
      for (int c = 0; c < 24; c++) begin
        bit          st, mw, rdy;
        logic [31:0] adr, dat;
        st  = ($urandom % 25) == 0;
        mw  = ($urandom % 3) == 0;
        rdy = ($urandom % 2) == 0;
        case ($urandom % 4)
          0: adr = 32'd84;
          1: adr = 32'd80;
          2: adr = 32'd0;
          default: adr = $urandom;
        endcase
        dat = (($urandom % 2) == 0) ? 32'h96 : $urandom;
        if (adr == 32'd84 && ($urandom % 3) != 0) mw = 0;
        cycle(st, mw, adr, dat, rdy);
      end
    end

    // Asynchronous reset between clock edges in the middle of a run.
    begin_run();
    cycle(0, 1, 32'd8, 32'h22, 0);
    cycle(0, 1, 32'd12, 32'h33, 0);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1;
    idle(2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Hardware run-controller and checker that sits directly downstream of the single-cycle MIPS computer.
- Consumes the computer's data-memory write bus (memwrite, dataadr, writedata) and drives the computer's reset input.
- Sequences a run, logs every store into a small FIFO, and flags pass/fail when the program stores its result to a fixed address, or fails when a cycle timeout expires.
- Replaces bench-side result polling so the check also works on FPGA.

Parameters:
- N, 32, data and address width of the monitored bus.
- RESULT_ADDR, 84, byte address the program's result store targets.
- EXPECTED, 32'h96, required result value.
- TIMEOUT, 1024, RUN cycles allowed before a timeout failure; must be >= 2.
- CNT_W, 16, width of the cycle and write counters.
- LOG_DEPTH, 8, FIFO entries; power of 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run from IDLE, PASS or FAIL.
- memwrite  in  1  computer store strobe.
- dataadr  in  N  computer store address.
- writedata  in  N  computer store data.
- cpu_reset  out  1  active-high reset to the computer.
- running  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail_mismatch  out  1  FAIL caused by a wrong value at RESULT_ADDR.
- fail_timeout  out  1  FAIL caused by timeout.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- write_count  out  CNT_W  stores observed in RUN; saturates at all-ones.
- log_valid  out  1  FIFO non-empty.
- log_ready  in  1  consumer pop.
- log_addr  out  N  head entry address.
- log_data  out  N  head entry data.
- log_overflow  out  1  sticky; a store was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, cpu_reset=1, every other output 0, FIFO empty.
- IDLE: cpu_reset=1. start -> HOLD.
- HOLD: cpu_reset=1 for exactly 2 cycles, then RUN.
  - On entering HOLD, clear cycle_count, write_count, FIFO, log_overflow and all flags.
- RUN: cpu_reset=0, running=1.
  - cycle_count increments every RUN cycle; it reads 0 in the first RUN cycle.
  - Bus inputs are sampled only in RUN; they are ignored in every other state.
  - memwrite=1 in a RUN cycle: push {dataadr, writedata} into the FIFO and increment write_count.
  - memwrite=1 and dataadr==RESULT_ADDR and writedata==EXPECTED -> PASS next cycle.
  - memwrite=1 and dataadr==RESULT_ADDR and writedata!=EXPECTED -> FAIL with fail_mismatch=1.
  - No result store and cycle_count==TIMEOUT-1 -> FAIL with fail_timeout=1.
  - Result store and timeout in the same cycle: the result store wins.
  - start while in RUN is ignored.
- PASS and FAIL: cpu_reset=1 (computer frozen), done=1, flags hold.
  - cycle_count and write_count hold.
  - FIFO stays readable.
  - start -> HOLD (restart).
- Flag latency: a store in RUN cycle k gives pass or fail_* = 1 at the posedge ending cycle k, visible in cycle k+1.
  - The terminating store is itself logged.
- FIFO:
  - First-word-fall-through: log_addr and log_data are valid whenever log_valid=1.
  - Pop when log_valid && log_ready.
  - Push while full: entry dropped, log_overflow=1, write_count still increments.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop while empty: no effect.
  - Pointers wrap modulo LOG_DEPTH; occupancy counter width is log2(LOG_DEPTH)+1.
- Reset asserted mid-run: immediate return to IDLE with cpu_reset=1.

Test Plan:
- Pass run: reset_n low for 2 cycles, start, drive memwrite with (80, 0x7) then (84, 0x96) in later cycles -> pass=1 one cycle after the second store, cpu_reset=1, write_count=2, FIFO pops (80, 0x7) then (84, 0x96).
- Mismatch: store (84, 0x95) -> fail_mismatch=1, pass=0, done=1.
- Timeout: TIMEOUT=16, no stores -> fail_timeout=1 after cycle_count reaches 15; store (84, 0x96) in cycle 15 instead -> pass=1.
- Overflow: 10 stores to address 0 with log_ready=0 -> 8 entries retained, log_overflow=1, write_count=10; full with simultaneous pop and push -> no overflow change.
- Sequencing: check cpu_reset is high for exactly 2 cycles after start; start during RUN is ignored; start from PASS clears counters and the FIFO.
- Async reset: reset_n low mid-RUN between clock edges -> cpu_reset=1 and running=0 immediately, FIFO empty.
